// File: rtl/io_cell_pkg.sv
// io_cell_pkg: SB_IO output mode codes and the shared mode decode.
package io_cell_pkg;

    localparam logic [3:0] OUT_REGISTERED = 4'b0101;
    localparam logic [3:0] OUT_DDR        = 4'b0100;
    localparam logic [3:0] OUT_COMB       = 4'b0110;

    localparam logic [5:0] PIN_OUTPUT_REGISTERED = 6'b010100;
    localparam logic [5:0] PIN_OUTPUT_DDR        = 6'b010000;

    typedef enum logic [1:0] {
        MODE_DISABLED,
        MODE_REGISTERED,
        MODE_DDR,
        MODE_COMB
    } out_mode_e;

    // Takes only PIN_TYPE[5:2]; the input-mode bits play no part in an output-only cell.
    function automatic out_mode_e decode_mode(input logic [3:0] out_code);
        return out_code == OUT_REGISTERED ? MODE_REGISTERED :
               out_code == OUT_DDR        ? MODE_DDR        :
               out_code == OUT_COMB       ? MODE_COMB       : MODE_DISABLED;
    endfunction

endpackage

// File: rtl/io_out_cell.sv
// io_out_cell: one SB_IO-style output pad cell (registered, DDR, comb or disabled).
module io_out_cell
    import io_cell_pkg::*;
#(
    parameter logic [5:0] PIN_TYPE = PIN_OUTPUT_REGISTERED
) (
    input  logic clk,
    input  logic resetn,
    input  logic ce,
    input  logic d_out_0,
    input  logic d_out_1,
    output logic package_pin
);

    localparam out_mode_e MODE = decode_mode(PIN_TYPE[5:2]);

    logic rise_q, rise_d, fall_q, fall_d;

    always_comb begin
        rise_d = ce ? d_out_0 : rise_q;
        fall_d = ce ? d_out_1 : fall_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) rise_q <= 1'b0;
        else         rise_q <= rise_d;
    end

    always_ff @(negedge clk or negedge resetn) begin
        if (!resetn) fall_q <= 1'b0;
        else         fall_q <= fall_d;
    end

    // DDR output muxes on clk itself, so each phase shows its own capture.
    always_comb begin
        package_pin = MODE == MODE_COMB       ? d_out_0 :
                      MODE == MODE_REGISTERED ? rise_q  :
                      MODE == MODE_DDR        ? (clk ? rise_q : fall_q) : 1'b0;
    end

endmodule

// File: rtl/io_out_cell_bank.sv
// io_out_cell_bank: WIDTH independent io_out_cell pads sharing clock, reset and enable.
module io_out_cell_bank
    import io_cell_pkg::*;
#(
    parameter int         WIDTH    = 1,
    parameter logic [5:0] PIN_TYPE = PIN_OUTPUT_REGISTERED
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             ce,
    input  logic [WIDTH-1:0] d_out_0,
    input  logic [WIDTH-1:0] d_out_1,
    output logic [WIDTH-1:0] package_pin
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        io_out_cell #(.PIN_TYPE(PIN_TYPE)) u_cell (
            .clk        (clk),
            .resetn     (resetn),
            .ce         (ce),
            .d_out_0    (d_out_0[i]),
            .d_out_1    (d_out_1[i]),
            .package_pin(package_pin[i])
        );
    end

endmodule

// File: tb/tb_io_out_cell_bank.sv
// tb_io_out_cell_bank: directed and random checks of all output modes against a phase-level model.
module tb_io_out_cell_bank;
    import io_cell_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        ce = 1'b1;
    logic [14:0] d0 = '0, d1 = '0;
    logic [14:0] pin_reg, pin_ddr, pin_comb, pin_dis;
    logic        pin_pix;

    logic [14:0] m_rise = '0, m_fall = '0;
    logic        m_pix_fall = 1'b0;
    int checks = 0, errors = 0;

    io_out_cell_bank #(.WIDTH(15), .PIN_TYPE(PIN_OUTPUT_REGISTERED)) u_reg (
        .clk(clk), .resetn(resetn), .ce(ce), .d_out_0(d0), .d_out_1(d1), .package_pin(pin_reg));
    io_out_cell_bank #(.WIDTH(15), .PIN_TYPE(PIN_OUTPUT_DDR)) u_ddr (
        .clk(clk), .resetn(resetn), .ce(ce), .d_out_0(d0), .d_out_1(d1), .package_pin(pin_ddr));
    io_out_cell_bank #(.WIDTH(1), .PIN_TYPE(PIN_OUTPUT_DDR)) u_pix (
        .clk(clk), .resetn(resetn), .ce(ce), .d_out_0(1'b0), .d_out_1(1'b1), .package_pin(pin_pix));
    io_out_cell_bank #(.WIDTH(15), .PIN_TYPE(6'b011000)) u_comb (
        .clk(clk), .resetn(resetn), .ce(ce), .d_out_0(d0), .d_out_1(d1), .package_pin(pin_comb));
    io_out_cell_bank #(.WIDTH(15), .PIN_TYPE(6'b000000)) u_dis (
        .clk(clk), .resetn(resetn), .ce(ce), .d_out_0(d0), .d_out_1(d1), .package_pin(pin_dis));

    task automatic chk(input string tag, input logic [14:0] got, input logic [14:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "/reg"},  pin_reg,  m_rise);
        chk({tag, "/ddr"},  pin_ddr,  clk ? m_rise : m_fall);
        chk({tag, "/pix"},  {14'd0, pin_pix}, {14'd0, clk ? 1'b0 : m_pix_fall});
        chk({tag, "/comb"}, pin_comb, d0);
        chk({tag, "/dis"},  pin_dis,  15'd0);
    endtask

    // Moves clk to level v, updates the model for that edge, checks mid-phase.
    task automatic half(input logic v, input string tag);
        #5;
        clk = v;
        if (resetn && ce) begin
            if (v) m_rise = d0;
            else begin
                m_fall = d1;
                m_pix_fall = 1'b1;
            end
        end
        #3;
        check_all(tag);
        #2;
    endtask

    task automatic cycle(input string tag);
        half(1'b1, tag);
        half(1'b0, tag);
    endtask

    task automatic drop_reset(input string tag);
        resetn = 1'b0;
        m_rise = '0;
        m_fall = '0;
        m_pix_fall = 1'b0;
        #1;
        check_all(tag);
    endtask

    initial begin
        d0 = 15'h7FFF;
        d1 = 15'h7FFF;
        #1;
        check_all("rst_init");
        repeat (3) cycle("rst_hold");
        resetn = 1'b1;
        d0 = 15'h5A3C;
        d1 = 15'h0000;
        #1;
        check_all("pre_edge");
        half(1'b1, "reg_5a3c");
        chk("reg_5a3c_exact", pin_reg, 15'h5A3C);
        half(1'b0, "first_low");
        d0 = 15'h7FFF;
        cycle("reg_7fff_a");
        half(1'b1, "reg_7fff_b");
        chk("reg_7fff_exact", pin_reg, 15'h7FFF);
        drop_reset("async_rst");
        chk("async_rst_exact", pin_reg, 15'h0000);
        half(1'b0, "rst_low");
        resetn = 1'b1;
        d0 = '0;
        d1 = 15'h7FFF;
        half(1'b1, "pix_first_high");
        half(1'b0, "pix_first_low");
        for (int k = 0; k < 4; k++) begin
            half(1'b1, "pix_high");
            chk("pix_inv_high", {14'd0, pin_pix}, 15'd0);
            half(1'b0, "pix_low");
            chk("pix_inv_low", {14'd0, pin_pix}, 15'd1);
        end
        d0 = 15'h7FFF;
        d1 = 15'h0000;
        cycle("ddr_10");
        d0 = 15'h0000;
        d1 = 15'h7FFF;
        cycle("ddr_01");
        d0 = 15'h7FFF;
        cycle("ce_setup");
        ce = 1'b0;
        d0 = 15'h0000;
        d1 = 15'h1234;
        repeat (3) cycle("ce_hold");
        chk("ce_hold_exact", pin_reg, 15'h7FFF);
        ce = 1'b1;
        half(1'b1, "ce_resume");
        chk("ce_resume_exact", pin_reg, 15'h0000);
        half(1'b0, "ce_resume_low");
        for (int k = 0; k < 300; k++) begin
            d0 = 15'($urandom);
            d1 = 15'($urandom);
            ce = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 40) == 0) begin
                drop_reset("rnd_rst");
                half(1'b1, "rnd_rst_high");
                half(1'b0, "rnd_rst_low");
                resetn = 1'b1;
            end
            half(1'b1, "rnd_high");
            d0 = 15'($urandom);
            #0 check_all("rnd_comb");
            half(1'b0, "rnd_low");
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
